// File: rtl/fetch_feeder.sv
// rtl/fetch_feeder.sv - instruction fetch request generator feeding a dual-issue queue
//
// Purpose: issues 8-byte fetch requests to the instruction cache, tracks their
// PCs in a tag FIFO, and turns each in-order 64-bit response into one or two
// pushes into a 4-entry downstream instruction queue. A redirect restarts the
// stream and converts every in-flight request into a pending discard.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   redirect, redirect_pc flush pulse and new word-aligned fetch target
//   req_valid/req_ready  request handshake, req_addr is 8-byte aligned
//   resp_valid/resp_data in-order 64-bit responses ([31:0] = word at addr+0)
//   valids               occupancy of the downstream queue
//   vinA/inA, vinB/inB   push slots, {pc, inst}; vinB implies vinA
module fetch_feeder #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [63:0] resp_data,
    input  logic [3:0]  valids,
    output logic        vinA,
    output logic [63:0] inA,
    output logic        vinB,
    output logic [63:0] inB
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [31:0]   fetch_pc_q;
    logic [31:0]   tag_q [MAX_OUT];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] out_q;
    logic [CW-1:0] drop_q;

    logic [31:0]   inflight_w;
    logic [31:0]   free_w;
    logic [31:0]   reserved_w;
    logic [31:0]   head_pc_w;
    logic [31:0]   redirect_drop_w;
    logic          hs_w;
    logic          resp_take_w;
    logic          resp_drop_w;
    logic          resp_push_w;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUT - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    always_comb begin
        inflight_w = 32'(out_q) + 32'(drop_q);
        free_w     = 32'd4 - 32'($countones(valids));
        // Every in-flight request may deliver two instructions, so space is
        // reserved for them before another request is allowed out.
        reserved_w = inflight_w << 1;
        req_valid  = ~rst & ~redirect & (inflight_w < 32'(MAX_OUT))
                     & (free_w >= reserved_w + 32'd2);
        req_addr   = {fetch_pc_q[31:3], 3'b000};
        hs_w       = req_valid & req_ready;

        resp_take_w = resp_valid & ~rst & ~redirect;
        resp_drop_w = resp_take_w & (drop_q != '0);
        // A response with nothing outstanding is a protocol error and is ignored.
        resp_push_w = resp_take_w & (drop_q == '0) & (out_q != '0);
        head_pc_w   = tag_q[rd_ptr_q];

        // A response arriving during the redirect retires one in-flight slot,
        // whether it belonged to the drop count or the outstanding count.
        redirect_drop_w = inflight_w;
        if (resp_valid && (inflight_w != 32'd0)) begin
            redirect_drop_w = inflight_w - 32'd1;
        end

        vinA = 1'b0;
        vinB = 1'b0;
        inA  = '0;
        inB  = '0;
        if (resp_push_w) begin
            vinA = 1'b1;
            if (head_pc_w[2]) begin
                // Entry into the upper half of the line: only one instruction.
                inA = {head_pc_w, resp_data[63:32]};
            end else begin
                inA  = {head_pc_w, resp_data[31:0]};
                vinB = 1'b1;
                inB  = {head_pc_w + 32'd4, resp_data[63:32]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_q[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            out_q      <= '0;
            drop_q     <= CW'(redirect_drop_w);
        end else begin
            if (hs_w) begin
                tag_q[wr_ptr_q] <= fetch_pc_q;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
                fetch_pc_q      <= {fetch_pc_q[31:3], 3'b000} + 32'd8;
            end
            if (resp_push_w) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (resp_drop_w) begin
                drop_q <= drop_q - CW'(1);
            end
            if (hs_w && !resp_push_w) begin
                out_q <= out_q + CW'(1);
            end else if (!hs_w && resp_push_w) begin
                out_q <= out_q - CW'(1);
            end
        end
    end

endmodule
